// File: rtl/bus_xfer_ctrl.sv
// Register-bus transfer sequencer: one instruction at a time, SETUP/STROBE/HOLD per step.
// Define BUS_TURNAROUND_EN to insert an all-idle GAP cycle between steps of one instruction.
module bus_xfer_ctrl #(
  parameter int unsigned NREG   = 8,
  parameter int unsigned RSEL_W = 3,
  localparam int unsigned IW    = 3 + 2 * RSEL_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_instr_valid,
  output logic            o_instr_ready,
  input  logic [IW-1:0]   i_instr,
  output logic [NREG-1:0] o_reg_en,
  output logic [NREG-1:0] o_reg_tri_en,
  output logic            o_imm_tri_en,
  output logic            o_a_en,
  output logic            o_g_en,
  output logic            o_g_tri_en,
  output logic            o_alu_sub,
  output logic            o_done,
  output logic            o_err
);

  typedef enum logic [1:0] {StIdle, StXfer, StGap, StDone} state_e;
  typedef enum logic [1:0] {PhSetup, PhStrobe, PhHold} phase_e;

  state_e              r_state, w_state_d;
  phase_e              r_phase, w_phase_d;
  logic [1:0]          r_step, w_step_d;
  logic [1:0]          r_op, w_op_d;
  logic [RSEL_W-1:0]   r_x, w_x_d, r_y, w_y_d;

  logic                r_ready, w_ready_d;
  logic [NREG-1:0]     r_reg_en, w_reg_en_d;
  logic [NREG-1:0]     r_reg_tri, w_reg_tri_d;
  logic                r_imm_tri, w_imm_tri_d;
  logic                r_a_en, w_a_en_d;
  logic                r_g_en, w_g_en_d;
  logic                r_g_tri, w_g_tri_d;
  logic                r_alu_sub, w_alu_sub_d;
  logic                r_done, w_done_d;
  logic                r_err, w_err_d;

  logic [2:0]          w_op;
  logic [RSEL_W-1:0]   w_x, w_y;
  logic                w_accept, w_illegal, w_strobe;
  logic [1:0]          w_last_step;

  assign w_op        = i_instr[IW-1 -: 3];
  assign w_x         = i_instr[2*RSEL_W-1 -: RSEL_W];
  assign w_y         = i_instr[RSEL_W-1:0];
  assign w_accept    = i_instr_valid & r_ready;
  assign w_illegal   = w_op[2] | (32'(w_x) >= NREG) | (32'(w_y) >= NREG);
  // ADD/SUB run three steps (Rx->A, Ry->G, G->Rx); MV/MVI run one.
  assign w_last_step = r_op[1] ? 2'd2 : 2'd0;

  always_comb begin
    w_state_d = r_state;
    w_phase_d = r_phase;
    w_step_d  = r_step;
    w_op_d    = r_op;
    w_x_d     = r_x;
    w_y_d     = r_y;
    w_err_d   = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        w_state_d = StIdle;
        if (w_accept) begin
          if (w_illegal) begin
            w_err_d = 1'b1;
          end else begin
            w_state_d = StXfer;
            w_phase_d = PhSetup;
            w_step_d  = 2'd0;
            w_op_d    = w_op[1:0];
            w_x_d     = w_x;
            w_y_d     = w_y;
          end
        end
      end
      StXfer: begin
        unique case (r_phase)
          PhSetup:  w_phase_d = PhStrobe;
          PhStrobe: w_phase_d = PhHold;
          default: begin
            if (r_step == w_last_step) begin
              w_state_d = StDone;
            end else begin
              w_step_d = r_step + 2'd1;
`ifdef BUS_TURNAROUND_EN
              w_state_d = StGap;
`else
              w_phase_d = PhSetup;
`endif
            end
          end
        endcase
      end
      StGap: begin
        w_state_d = StXfer;
        w_phase_d = PhSetup;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state and registered, so every strobe is a clean flop output.
  always_comb begin
    w_ready_d   = (w_state_d == StIdle) || (w_state_d == StDone);
    w_done_d    = (w_state_d == StDone);
    w_reg_en_d  = '0;
    w_reg_tri_d = '0;
    w_imm_tri_d = 1'b0;
    w_a_en_d    = 1'b0;
    w_g_en_d    = 1'b0;
    w_g_tri_d   = 1'b0;
    w_alu_sub_d = 1'b0;
    w_strobe    = (w_phase_d == PhStrobe);
    if (w_state_d == StXfer) begin
      if (!w_op_d[1]) begin
        if (w_op_d[0]) w_imm_tri_d = 1'b1;
        else           w_reg_tri_d[w_y_d] = 1'b1;
        if (w_strobe)  w_reg_en_d[w_x_d] = 1'b1;
      end else begin
        unique case (w_step_d)
          2'd0: begin
            w_reg_tri_d[w_x_d] = 1'b1;
            w_a_en_d           = w_strobe;
          end
          2'd1: begin
            w_reg_tri_d[w_y_d] = 1'b1;
            w_g_en_d           = w_strobe;
            w_alu_sub_d        = w_op_d[0];
          end
          default: begin
            w_g_tri_d = 1'b1;
            if (w_strobe) w_reg_en_d[w_x_d] = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_phase   <= PhSetup;
      r_step    <= '0;
      r_op      <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_ready   <= 1'b1;
      r_reg_en  <= '0;
      r_reg_tri <= '0;
      r_imm_tri <= 1'b0;
      r_a_en    <= 1'b0;
      r_g_en    <= 1'b0;
      r_g_tri   <= 1'b0;
      r_alu_sub <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_phase   <= w_phase_d;
      r_step    <= w_step_d;
      r_op      <= w_op_d;
      r_x       <= w_x_d;
      r_y       <= w_y_d;
      r_ready   <= w_ready_d;
      r_reg_en  <= w_reg_en_d;
      r_reg_tri <= w_reg_tri_d;
      r_imm_tri <= w_imm_tri_d;
      r_a_en    <= w_a_en_d;
      r_g_en    <= w_g_en_d;
      r_g_tri   <= w_g_tri_d;
      r_alu_sub <= w_alu_sub_d;
      r_done    <= w_done_d;
      r_err     <= w_err_d;
    end
  end

  assign o_instr_ready = r_ready;
  assign o_reg_en      = r_reg_en;
  assign o_reg_tri_en  = r_reg_tri;
  assign o_imm_tri_en  = r_imm_tri;
  assign o_a_en        = r_a_en;
  assign o_g_en        = r_g_en;
  assign o_g_tri_en    = r_g_tri;
  assign o_alu_sub     = r_alu_sub;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule
